// File: rtl/uart_rx_irq_ctrl.sv
// RX-path interrupt/flow controller: tracks FIFO level, raises level/timeout/parity/overrun causes, drives one registered IRQ.
// Optional high-water-mark output is enabled by defining UART_RX_IRQ_CTRL_HWM_EN.
module uart_rx_irq_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT_W  = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_en,
   input  logic [LVL_W-1:0]     cfg_thresh,
   input  logic [TIMEOUT_W-1:0] cfg_timeout,
   input  logic [3:0]           irq_mask,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 parity_err,
   input  logic [3:0]           clr,
   output logic [LVL_W-1:0]     level,
`ifdef UART_RX_IRQ_CTRL_HWM_EN
   output logic [LVL_W-1:0]     hwm,
`endif
   output logic [3:0]           status,
   output logic [7:0]           overrun_cnt,
   output logic                 irq
);

   typedef enum logic [1:0] {IDLE, WAIT, FIRED} state_t;

   localparam logic [TIMEOUT_W-1:0] TMAX = {TIMEOUT_W{1'b1}};

   logic [LVL_W-1:0]     level_q, level_nxt, thr_eff;
   logic                 full, empty, ovf, lvl_hit;
   logic [3:1]           sticky_q;
   logic [7:0]           ovr_cnt_q;
   logic                 irq_q;
   state_t               state_q, state_nxt;
   logic [TIMEOUT_W-1:0] timer_q, timer_nxt, timer_inc;
   logic                 fire;

   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty = (level_q == '0);
   assign ovf   = push & ~pop & full;

   always_comb begin
      level_nxt = level_q;
      if (push && !pop && !full)
         level_nxt = level_q + 1'b1;
      else if (pop && !push && !empty)
         level_nxt = level_q - 1'b1;
   end

   assign thr_eff = (cfg_thresh == '0) ? LVL_W'(1) : cfg_thresh;
   assign lvl_hit = cfg_en & (level_q >= thr_eff);

   // Timer saturates; fire only on an actual step onto cfg_timeout, so a late
   // cfg_timeout change never fires retroactively.
   assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;

   always_comb begin
      state_nxt = state_q;
      timer_nxt = timer_q;
      fire      = 1'b0;
      if (!cfg_en) begin
         state_nxt = IDLE;
         timer_nxt = '0;
      end else begin
         case (state_q)
            IDLE: begin
               timer_nxt = '0;
               if (level_nxt != '0)
                  state_nxt = WAIT;
            end
            WAIT: begin
               if (level_nxt == '0) begin
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end else if (push || pop) begin
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer_inc;
                  if (cfg_timeout != '0 && timer_q != TMAX && timer_inc == cfg_timeout) begin
                     fire      = 1'b1;
                     state_nxt = FIRED;
                  end
               end
            end
            FIRED: begin
               if (push || pop) begin
                  timer_nxt = '0;
                  state_nxt = (level_nxt != '0) ? WAIT : IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q   <= '0;
         state_q   <= IDLE;
         timer_q   <= '0;
         sticky_q  <= '0;
         ovr_cnt_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         level_q  <= level_nxt;
         state_q  <= state_nxt;
         timer_q  <= timer_nxt;
         // set wins over a simultaneous clear
         sticky_q <= (sticky_q & ~clr[3:1]) | ({ovf, parity_err, fire} & {3{cfg_en}});
         if (ovf && ovr_cnt_q != 8'hFF)
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
         irq_q <= cfg_en & |(status & irq_mask);
      end
   end

`ifdef UART_RX_IRQ_CTRL_HWM_EN
   logic [LVL_W-1:0] hwm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hwm_q <= '0;
      else if (clr[0])
         hwm_q <= level_q;
      else if (level_q > hwm_q)
         hwm_q <= level_q;
   end

   assign hwm = hwm_q;
`else
   logic unused_clr0;
   assign unused_clr0 = clr[0];
`endif

   assign level       = level_q;
   assign status      = {sticky_q, lvl_hit};
   assign overrun_cnt = ovr_cnt_q;
   assign irq         = irq_q;

endmodule

// File: doc/uart_rx_irq_ctrl.md
Name: uart_rx_irq_ctrl

Overview:
- Interrupt and flow controller for the UART receive path; runs in the system clock domain next to the RX FIFO.
- Tracks RX FIFO occupancy from enqueue/dequeue events.
- Raises level, character-timeout, parity-error and overrun interrupt causes, holds them as status flags, and combines them into a single registered, maskable IRQ line for the host.

Parameters:
- FIFO_DEPTH, 8, depth of the monitored RX FIFO (power of two, >=2).
- TIMEOUT_W, 16, width of the character-timeout counter and of cfg_timeout.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of level and cfg_thresh (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- cfg_en  in  1  controller enable.
- cfg_thresh  in  LVL_W  level interrupt threshold; 0 is treated as 1.
- cfg_timeout  in  TIMEOUT_W  idle clk cycles before the timeout cause; 0 disables timeout.
- irq_mask  in  4  cause enables: [0] level, [1] timeout, [2] parity, [3] overrun.
- push  in  1  one-cycle pulse: a frame was offered to the RX FIFO.
- pop  in  1  one-cycle pulse: RX FIFO dequeue handshake (valid & ready).
- parity_err  in  1  one-cycle pulse: the received frame had a parity error.
- clr  in  4  write-1-to-clear pulse for status[3:1]; bit 0 is ignored.
- level  out  LVL_W  current FIFO occupancy.
- status  out  4  [0] live level>=thresh, [1] timeout, [2] parity, [3] overrun (bits 3:1 sticky).
- overrun_cnt  out  8  count of dropped frames, saturating.
- irq  out  1  registered interrupt request.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low. All state resets to zero: level=0, status=0, overrun_cnt=0, irq=0, timer=0, FSM=IDLE.
- Level counter:
  - push & !pop: +1.
  - pop & !push: -1.
  - Both together: unchanged, including at level==FIFO_DEPTH.
  - push with level==FIFO_DEPTH and no pop: level unchanged, status[3] set, overrun_cnt+1 (saturates at 255).
  - pop with level==0: ignored, level stays 0.
  - The level counter runs regardless of cfg_en.
- status[0]: combinational, (level >= max(cfg_thresh,1)) & cfg_en.
- Sticky bits status[3:1]:
  - Set by their event in the cycle after the event.
  - Cleared by the matching clr bit.
  - If set and clear land in the same cycle, set wins.
  - Set only while cfg_en=1; clr works regardless of cfg_en.
- Timeout FSM, 16-bit timer, states IDLE, WAIT, FIRED:
  - IDLE: timer=0. Go to WAIT when level becomes >0 and cfg_en=1.
  - WAIT: timer increments each cycle. Timer resets to 0 on push or pop.
    - When timer==cfg_timeout and cfg_timeout!=0: set status[1], go to FIRED (first cause cycle = cfg_timeout cycles after the last push/pop).
    - Go to IDLE when level reaches 0.
  - FIRED: timer held.
    - push or pop with resulting level>0: go to WAIT with timer=0.
    - Resulting level==0: go to IDLE.
    - Only one timeout per idle gap.
  - cfg_en=0 in any state: forced to IDLE next cycle, timer=0.
  - cfg_timeout changed mid-count: the new value is compared on the following cycle; no retroactive fire if the timer already exceeds it. Fire happens only on equality, and the timer stops at 2^TIMEOUT_W-1 without wrapping.
- irq: register of cfg_en & |(status & irq_mask), so it lags status by one cycle. irq drops one cycle after the last enabled cause clears.
- Reset mid-operation: every output returns to its reset value asynchronously; no pending cause survives.

Optional Feature:
- Macro UART_RX_IRQ_CTRL_HWM_EN.
- When defined, adds output port hwm (LVL_W):
  - High-water mark of level since reset.
  - Updates one cycle after level exceeds it.
  - Reset to the current level when clr[0]=1.
- When undefined, the port and its register are absent and clr[0] is unused.

Test Plan:
- Level irq: cfg_en=1, thresh=4, mask=0001; 4 pushes on consecutive cycles -> level=4, status[0]=1 on the cycle after the 4th push, irq=1 one cycle later; 1 pop -> irq=0 two cycles after the pop.
- Timeout: thresh=8, timeout=10, mask=0010; 1 push then idle -> status[1]=1 exactly 10 cycles after the push and only once; clr=0010 -> status[1]=0 and irq=0 a cycle later; a further push re-arms the timeout.
- Overrun: 8 pushes, then 3 more pushes -> level=8, status[3]=1, overrun_cnt=3; push+pop in the same cycle at full -> level=8, overrun_cnt unchanged.
- Parity set vs clear: parity_err and clr[2] in the same cycle -> status[2]=1; clr[2] alone on the next cycle -> 0.
- Disable/reset: level=3 in WAIT, drop cfg_en -> FSM IDLE, irq=0, level stays 3; assert rst_n=0 mid-count -> every output 0 immediately.
- Boundary: timeout=0 with level>0 held for 1000 cycles -> status[1] never set; pop at level=0 -> level stays 0.
